// File: rtl/intdiv_sched.sv
// Round-robin front end that shares one fixed-latency pipelined signed divider
// among NREQ requesters and steers results into per-requester result FIFOs.
module intdiv_sched #(
    parameter int N    = 4,
    parameter int LAT  = 6,
    parameter int NREQ = 2,
    parameter int FD   = 4
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [NREQ-1:0]     req_valid,
    output logic [NREQ-1:0]     req_ready,
    input  logic [NREQ*N-1:0]   req_x,
    input  logic [NREQ*N-1:0]   req_y,
    output logic [N-1:0]        div_x,
    output logic [N-1:0]        div_y,
    input  logic [N-1:0]        div_z,
    input  logic [N-1:0]        div_r,
    output logic [NREQ-1:0]     rsp_valid,
    input  logic [NREQ-1:0]     rsp_ready,
    output logic [NREQ*N-1:0]   rsp_z,
    output logic [NREQ*N-1:0]   rsp_r,
    output logic [NREQ-1:0]     rsp_err,
    output logic                busy
);
    localparam int TW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CW = $clog2(FD + 1);
    localparam int PW = (FD > 1) ? $clog2(FD) : 1;
    localparam int EW = 2 * N + 1;
    localparam logic [N-1:0] MIN_VAL = {1'b1, {(N-1){1'b0}}};

    typedef struct packed {
        logic          valid;
        logic [TW-1:0] tag;
        logic          dbz;
        logic          ovf;
        logic [N-1:0]  x;
    } shadow_t;

    function automatic logic [PW-1:0] fifo_inc(input logic [PW-1:0] p);
        return (int'(p) == FD - 1) ? '0 : p + 1'b1;
    endfunction

    logic [TW-1:0]   ptr_reg;
    shadow_t         shadow_reg [LAT];
    shadow_t         shadow_next;
    shadow_t         ret;
    logic [EW-1:0]   ret_entry;
    logic [NREQ-1:0] eligible;
    logic [NREQ-1:0] grant;
    logic            grant_any;
    logic [TW-1:0]   grant_idx;
    logic [N-1:0]    grant_x;
    logic [N-1:0]    grant_y;
    logic            grant_dbz;
    logic            grant_ovf;
    logic            issue_normal;
    logic [LAT-1:0]  stage_valid;

    // Two passes give "first eligible at or after the pointer, wrapping".
    always_comb begin
        grant     = '0;
        grant_any = 1'b0;
        grant_idx = '0;
        grant_x   = '0;
        grant_y   = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (!grant_any && eligible[k] && k >= int'(ptr_reg)) begin
                grant_any = 1'b1;
                grant[k]  = 1'b1;
                grant_idx = TW'(k);
                grant_x   = req_x[k*N +: N];
                grant_y   = req_y[k*N +: N];
            end
        end
        for (int k = 0; k < NREQ; k++) begin
            if (!grant_any && eligible[k]) begin
                grant_any = 1'b1;
                grant[k]  = 1'b1;
                grant_idx = TW'(k);
                grant_x   = req_x[k*N +: N];
                grant_y   = req_y[k*N +: N];
            end
        end
    end

    assign req_ready    = grant;
    assign grant_dbz    = (grant_y == '0);
    assign grant_ovf    = (grant_x == MIN_VAL) && (grant_y == '1);
    assign issue_normal = grant_any && !grant_dbz && !grant_ovf;
    // Idle and locally-resolved ops feed the divider a harmless 0/1.
    assign div_x        = issue_normal ? grant_x : '0;
    assign div_y        = issue_normal ? grant_y : N'(1);

    always_ff @(posedge clock) begin
        if (reset) begin
            ptr_reg <= '0;
        end else if (grant_any) begin
            ptr_reg <= (int'(grant_idx) == NREQ - 1) ? '0 : grant_idx + 1'b1;
        end
    end

    assign shadow_next.valid = grant_any;
    assign shadow_next.tag   = grant_idx;
    assign shadow_next.dbz   = grant_dbz;
    assign shadow_next.ovf   = grant_ovf;
    assign shadow_next.x     = grant_x;

    // Shadow pipe runs in lockstep with the divider; it never stalls.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < LAT; i++) begin
                shadow_reg[i] <= '0;
            end
        end else begin
            shadow_reg[0] <= shadow_next;
            for (int i = 1; i < LAT; i++) begin
                shadow_reg[i] <= shadow_reg[i-1];
            end
        end
    end

    generate
        for (genvar gi = 0; gi < LAT; gi++) begin : g_stage
            assign stage_valid[gi] = shadow_reg[gi].valid;
        end
    endgenerate

    assign ret = shadow_reg[LAT-1];

    // Divide-by-zero wins over overflow when both could apply.
    always_comb begin
        ret_entry = {div_z, div_r, 1'b0};
        if (ret.dbz) begin
            ret_entry = {{N{1'b1}}, ret.x, 1'b1};
        end else if (ret.ovf) begin
            ret_entry = {MIN_VAL, {N{1'b0}}, 1'b1};
        end
    end

    generate
        for (genvar gi = 0; gi < NREQ; gi++) begin : g_req
            logic [CW-1:0] inflight_reg;
            logic [CW-1:0] count_reg;
            logic [PW-1:0] wr_ptr_reg;
            logic [PW-1:0] rd_ptr_reg;
            logic [EW-1:0] mem_reg [FD];
            logic          push;
            logic          pop;

            assign push          = ret.valid && (ret.tag == TW'(gi));
            assign pop           = rsp_valid[gi] && rsp_ready[gi];
            // Credit counts only registered state; a pop this cycle frees a slot next cycle.
            assign eligible[gi]  = !reset && req_valid[gi] &&
                                   ((int'(inflight_reg) + int'(count_reg)) < FD);
            assign rsp_valid[gi] = (count_reg != '0);
            assign {rsp_z[gi*N +: N], rsp_r[gi*N +: N], rsp_err[gi]} =
                rsp_valid[gi] ? mem_reg[rd_ptr_reg] : '0;

            always_ff @(posedge clock) begin
                if (push) begin
                    mem_reg[wr_ptr_reg] <= ret_entry;
                end
            end

            always_ff @(posedge clock) begin
                if (reset) begin
                    inflight_reg <= '0;
                    count_reg    <= '0;
                    wr_ptr_reg   <= '0;
                    rd_ptr_reg   <= '0;
                end else begin
                    if (grant[gi] && !push) begin
                        inflight_reg <= inflight_reg + 1'b1;
                    end else if (!grant[gi] && push) begin
                        inflight_reg <= inflight_reg - 1'b1;
                    end
                    if (push && !pop) begin
                        count_reg <= count_reg + 1'b1;
                    end else if (!push && pop) begin
                        count_reg <= count_reg - 1'b1;
                    end
                    if (push) begin
                        wr_ptr_reg <= fifo_inc(wr_ptr_reg);
                    end
                    if (pop) begin
                        rd_ptr_reg <= fifo_inc(rd_ptr_reg);
                    end
                end
            end
        end
    endgenerate

    assign busy = (|stage_valid) || (|rsp_valid);

endmodule

// File: tb/tb_intdiv_sched.sv
// Directed bench for intdiv_sched with a behavioural pipelined divider and
// hand-computed per-requester result tables.
module tb_intdiv_sched;
    localparam int N    = 4;
    localparam int LAT  = 6;
    localparam int NREQ = 2;
    localparam int FD   = 4;

    logic            clock;
    logic            reset;
    logic [1:0]      req_valid;
    logic [1:0]      req_ready;
    logic [7:0]      req_x;
    logic [7:0]      req_y;
    logic [3:0]      div_x;
    logic [3:0]      div_y;
    logic [3:0]      div_z;
    logic [3:0]      div_r;
    logic [1:0]      rsp_valid;
    logic [1:0]      rsp_ready;
    logic [7:0]      rsp_z;
    logic [7:0]      rsp_r;
    logic [1:0]      rsp_err;
    logic            busy;

    intdiv_sched #(.N(N), .LAT(LAT), .NREQ(NREQ), .FD(FD)) dut (
        .clock     (clock),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_x     (req_x),
        .req_y     (req_y),
        .div_x     (div_x),
        .div_y     (div_y),
        .div_z     (div_z),
        .div_r     (div_r),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_z     (rsp_z),
        .rsp_r     (rsp_r),
        .rsp_err   (rsp_err),
        .busy      (busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Behavioural divider: truncating signed division, LAT-cycle pipe.
    function automatic logic [7:0] divf(input logic [3:0] x, input logic [3:0] y);
        int a;
        int b;
        int q;
        int r;
        a = int'($signed(x));
        b = int'($signed(y));
        if (b == 0) return 8'h00;
        q = a / b;
        r = a % b;
        return {q[3:0], r[3:0]};
    endfunction

    logic [3:0] mz [LAT];
    logic [3:0] mr [LAT];
    always @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < LAT; i++) begin
                mz[i] <= 4'h0;
                mr[i] <= 4'h0;
            end
        end else begin
            {mz[0], mr[0]} <= divf(div_x, div_y);
            for (int i = 1; i < LAT; i++) begin
                mz[i] <= mz[i-1];
                mr[i] <= mr[i-1];
            end
        end
    end
    assign div_z = mz[LAT-1];
    assign div_r = mr[LAT-1];

    int n_assert = 0;
    int n_fail   = 0;

    logic [3:0] tx [2][32];
    logic [3:0] ty [2][32];
    logic [3:0] tz [2][32];
    logic [3:0] tr [2][32];
    logic       te [2][32];
    int nops [2];
    int iop  [2];
    int irs  [2];

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic add_op(input int k, input logic [3:0] x, input logic [3:0] y,
                          input logic [3:0] z, input logic [3:0] r, input logic e);
        tx[k][nops[k]] = x;
        ty[k][nops[k]] = y;
        tz[k][nops[k]] = z;
        tr[k][nops[k]] = r;
        te[k][nops[k]] = e;
        nops[k]++;
    endtask

    // One clock cycle: drive requests, check grants/issue/responses, advance.
    task automatic cycle(input logic [1:0] v, input logic [1:0] exp_rdy);
        logic [1:0] vv;
        for (int k = 0; k < 2; k++) begin
            vv[k] = v[k] && (iop[k] < nops[k]);
            req_x[k*4 +: 4] = vv[k] ? tx[k][iop[k]] : 4'h0;
            req_y[k*4 +: 4] = vv[k] ? ty[k][iop[k]] : 4'h0;
        end
        req_valid = vv;
        #1;
        chk("req_ready", req_ready, exp_rdy);
        for (int k = 0; k < 2; k++) begin
            if (req_ready[k] && vv[k]) begin
                chk($sformatf("div_x req%0d op%0d", k, iop[k]), div_x,
                    te[k][iop[k]] ? 4'h0 : tx[k][iop[k]]);
                chk($sformatf("div_y req%0d op%0d", k, iop[k]), div_y,
                    te[k][iop[k]] ? 4'h1 : ty[k][iop[k]]);
                iop[k]++;
            end
        end
        for (int k = 0; k < 2; k++) begin
            if (rsp_valid[k]) begin
                if (irs[k] >= nops[k]) begin
                    chk($sformatf("spurious rsp_valid[%0d]", k), rsp_valid[k], 1'b0);
                end else if (rsp_ready[k]) begin
                    chk($sformatf("rsp_z req%0d op%0d", k, irs[k]), rsp_z[k*4 +: 4], tz[k][irs[k]]);
                    chk($sformatf("rsp_r req%0d op%0d", k, irs[k]), rsp_r[k*4 +: 4], tr[k][irs[k]]);
                    chk($sformatf("rsp_err req%0d op%0d", k, irs[k]), rsp_err[k], te[k][irs[k]]);
                    irs[k]++;
                end
            end
        end
        @(posedge clock);
        #1;
    endtask

    task automatic single(input int k);
        int cyc;
        logic [1:0] m;
        m = (k == 0) ? 2'b01 : 2'b10;
        rsp_ready = 2'b00;
        cycle(m, m);
        cyc = 1;
        chk("busy in flight", busy, 1'b1);
        while (!rsp_valid[k] && cyc < 40) begin
            cycle(2'b00, 2'b00);
            cyc++;
        end
        chk($sformatf("latency req%0d", k), cyc, LAT + 1);
        rsp_ready = 2'b11;
        cycle(2'b00, 2'b00);
        chk("rsp_valid after pop", rsp_valid, 2'b00);
        chk("busy idle", busy, 1'b0);
        chk("rsp_z while empty", rsp_z, 8'h00);
    endtask

    task automatic drain();
        int cyc;
        cyc = 0;
        rsp_ready = 2'b11;
        while ((irs[0] < nops[0] || irs[1] < nops[1]) && cyc < 60) begin
            cycle(2'b00, 2'b00);
            cyc++;
        end
        chk("drain complete", (irs[0] == nops[0]) && (irs[1] == nops[1]), 1'b1);
        chk("busy after drain", busy, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL global timeout: observed no finish, expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        int base;
        for (int k = 0; k < 2; k++) begin
            nops[k] = 0;
            iop[k]  = 0;
            irs[k]  = 0;
        end
        reset = 1'b1;
        req_valid = 2'b00;
        rsp_ready = 2'b00;
        req_x = 8'h00;
        req_y = 8'h00;
        @(posedge clock);
        #1;
        // Request held during reset must not be accepted.
        req_valid = 2'b01;
        req_x = 8'h07;
        req_y = 8'h03;
        #1;
        chk("reset req_ready", req_ready, 2'b00);
        chk("reset rsp_valid", rsp_valid, 2'b00);
        chk("reset busy", busy, 1'b0);
        chk("reset rsp_z", rsp_z, 8'h00);
        chk("reset rsp_r", rsp_r, 8'h00);
        chk("reset rsp_err", rsp_err, 2'b00);
        chk("reset div_x", div_x, 4'h0);
        chk("reset div_y", div_y, 4'h1);
        @(posedge clock);
        #1;
        reset = 1'b0;
        req_valid = 2'b00;

        // Single ops: plain, signed on requester 1, specials on requester 0.
        add_op(0, 4'h7, 4'h3, 4'h2, 4'h1, 1'b0); single(0);   //  7/3  = 2 r 1
        add_op(1, 4'h9, 4'h4, 4'hF, 4'hD, 1'b0); single(1);   // -7/4  = -1 r -3
        add_op(1, 4'h6, 4'h4, 4'h1, 4'h2, 1'b0); single(1);   //  6/4  = 1 r 2
        add_op(1, 4'h9, 4'hE, 4'h3, 4'hF, 1'b0); single(1);   // -7/-2 = 3 r -1
        add_op(0, 4'h5, 4'h0, 4'hF, 4'h5, 1'b1); single(0);   //  5/0  -> dbz
        add_op(0, 4'h8, 4'hF, 4'h8, 4'h0, 1'b1); single(0);   // -8/-1 -> ovf
        add_op(0, 4'h9, 4'h2, 4'hD, 4'hF, 1'b0); single(0);   // -7/2  = -3 r -1
        add_op(1, 4'h7, 4'hE, 4'hD, 4'h1, 1'b0); single(1);   //  7/-2 = -3 r 1

        // Fairness: both requesters always valid, grants alternate 0,1,0,1.
        add_op(0, 4'h1, 4'h2, 4'h0, 4'h1, 1'b0);
        add_op(0, 4'h2, 4'h2, 4'h1, 4'h0, 1'b0);
        add_op(0, 4'h3, 4'h2, 4'h1, 4'h1, 1'b0);
        add_op(0, 4'h4, 4'h2, 4'h2, 4'h0, 1'b0);
        add_op(1, 4'hF, 4'h2, 4'h0, 4'hF, 1'b0);
        add_op(1, 4'hE, 4'h2, 4'hF, 4'h0, 1'b0);
        add_op(1, 4'hD, 4'h2, 4'hF, 4'hF, 1'b0);
        add_op(1, 4'hC, 4'h2, 4'hE, 4'h0, 1'b0);
        rsp_ready = 2'b11;
        for (int c = 0; c < 8; c++) begin
            cycle(2'b11, (c % 2 == 0) ? 2'b01 : 2'b10);
        end
        drain();

        // Backpressure: requester 0 fills its FD credits, requester 1 still served.
        add_op(0, 4'h7, 4'h1, 4'h7, 4'h0, 1'b0);
        add_op(0, 4'h6, 4'h3, 4'h2, 4'h0, 1'b0);
        add_op(0, 4'h5, 4'h2, 4'h2, 4'h1, 1'b0);
        add_op(0, 4'hB, 4'h3, 4'hF, 4'hE, 1'b0);   // -5/3 = -1 r -2
        add_op(0, 4'h3, 4'hD, 4'hF, 4'h0, 1'b0);   //  3/-3 = -1 r 0
        add_op(1, 4'h7, 4'h7, 4'h1, 4'h0, 1'b0);
        add_op(1, 4'hA, 4'h7, 4'h0, 4'hA, 1'b0);   // -6/7 = 0 r -6
        add_op(1, 4'h4, 4'h5, 4'h0, 4'h4, 1'b0);
        rsp_ready = 2'b10;
        for (int c = 0; c < 4; c++) cycle(2'b01, 2'b01);
        cycle(2'b11, 2'b10);
        cycle(2'b01, 2'b00);
        cycle(2'b11, 2'b10);
        cycle(2'b01, 2'b00);
        cycle(2'b11, 2'b10);
        cycle(2'b01, 2'b00);
        chk("bp fifo0 held", rsp_valid[0], 1'b1);
        chk("bp busy", busy, 1'b1);
        rsp_ready = 2'b11;
        cycle(2'b01, 2'b00);   // full FIFO pops now; credit visible next cycle
        cycle(2'b01, 2'b01);
        drain();

        // Reset with ops in flight: results discarded, new op unaffected.
        base = nops[0];
        add_op(0, 4'h7, 4'h1, 4'h7, 4'h0, 1'b0);
        add_op(0, 4'h6, 4'h3, 4'h2, 4'h0, 1'b0);
        add_op(0, 4'h5, 4'h2, 4'h2, 4'h1, 1'b0);
        add_op(0, 4'hA, 4'hC, 4'h1, 4'hE, 1'b0);   // -6/-4 = 1 r -2
        rsp_ready = 2'b11;
        for (int c = 0; c < 3; c++) cycle(2'b01, 2'b01);
        reset = 1'b1;
        cycle(2'b01, 2'b00);
        reset = 1'b0;
        irs[0] = base + 3;
        chk("post-reset rsp_valid", rsp_valid, 2'b00);
        chk("post-reset busy", busy, 1'b0);
        single(0);
        for (int c = 0; c < LAT + 2; c++) cycle(2'b00, 2'b00);
        chk("final busy", busy, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
